// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader; header {hi,lo}=N, then N 16-bit words written to program memory.
// Ports: clk, reset (async low), start, in_data/in_valid/in_ready, we_mem/addr_mem/data_mem, cpu_run, busy, err_len, illegal, words_loaded.
module prog_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        we_mem,
  output logic [9:0]  addr_mem,
  output logic [15:0] data_mem,
  output logic        cpu_run,
  output logic        busy,
  output logic        err_len,
  output logic        illegal,
  output logic [10:0] words_loaded
);

  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, W_HI,
    W_LO, WRITE, DONE, ERR
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [7:0]  hdr_hi;
  logic [10:0] n_words;
  logic [15:0] hdr;
  logic        hdr_bad;
  logic [5:0]  op;
  logic        op_ok;
  logic        last;

  assign hdr     = {hdr_hi, in_data};
  assign hdr_bad = (hdr == 16'd0) || (hdr > 16'd1024);
  assign op      = data_mem[15:10];
  assign last    = (words_loaded + 11'd1) == n_words;

  always_comb begin
    op_ok = 1'b0;
    unique case (1'b1)
      op[5]:                      op_ok = 1'b1;
      (op[5:2] == 4'b0000):       op_ok = 1'b1;
      (op >= 6'd8 && op <= 6'd10): op_ok = 1'b1;
      default:                    op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt      = state;
    in_ready = 1'b0;
    busy     = 1'b1;
    we_mem   = 1'b0;
    cpu_run  = 1'b0;
    unique case (state)
      IDLE, ERR: begin
        busy = 1'b0;
        if (start) nxt = HDR_HI;
      end
      DONE: begin
        busy    = 1'b0;
        cpu_run = 1'b1;
        if (start) nxt = HDR_HI;
      end
      HDR_HI: begin
        in_ready = 1'b1;
        if (in_valid) nxt = HDR_LO;
      end
      HDR_LO: begin
        in_ready = 1'b1;
        if (in_valid) nxt = hdr_bad ? ERR : W_HI;
      end
      W_HI: begin
        in_ready = 1'b1;
        if (in_valid) nxt = W_LO;
      end
      W_LO: begin
        in_ready = 1'b1;
        if (in_valid) nxt = WRITE;
      end
      WRITE: begin
        we_mem = 1'b1;
        nxt    = last ? DONE : W_HI;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hdr_hi       <= '0;
      n_words      <= '0;
      addr_mem     <= '0;
      data_mem     <= '0;
      err_len      <= 1'b0;
      illegal      <= 1'b0;
      words_loaded <= '0;
    end else begin
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            err_len      <= 1'b0;
            illegal      <= 1'b0;
            words_loaded <= '0;
            addr_mem     <= '0;
          end
        end
        HDR_HI: if (in_valid) hdr_hi <= in_data;
        HDR_LO: begin
          if (in_valid) begin
            if (hdr_bad) err_len <= 1'b1;
            else         n_words <= hdr[10:0];
          end
        end
        W_HI: if (in_valid) data_mem[15:8] <= in_data;
        W_LO: if (in_valid) data_mem[7:0] <= in_data;
        WRITE: begin
          addr_mem     <= addr_mem + 10'd1;
          words_loaded <= words_loaded + 11'd1;
          if (!op_ok) illegal <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
